fifo_input_debouncer: RTL and testbench
=======================================

// Module: fifo_input_debouncer
// PURPOSE
//  Front-end stage feeding the 2^s x n FIFO on the board. Cleans raw push-button
//  inputs (write, read) and data switches into stable, glitch-free levels for the
//  FIFO's wr/rd/in ports. The FIFO acts on the falling edge of wr/rd, so this block
//  guarantees one clean high level per physical press and a data word held stable
//  across that falling edge. Buttons are mutually exclusive, so the FIFO never
//  sees simultaneous wr/rd.
// PARAMETERS
//  W          3          data switch width; equals FIFO parameter n
//  DB_CYCLES  1_000_000  stable cycles required to accept a level change; must be >=2
//  CNT_W      20         counter width; 2**CNT_W > DB_CYCLES
// PORTS
//  clk      in   1   single system clock; all logic on posedge
//  rst      in   1   synchronous, active-high reset
//  wr_btn   in   1   raw async write button, active-high
//  rd_btn   in   1   raw async read button, active-high
//  sw       in   W   raw async data switches
//  wr_lvl   out  1   debounced write level -> FIFO wr
//  rd_lvl   out  1   debounced read level -> FIFO rd
//  wr_rel   out  1   1-cycle pulse when wr_lvl falls (write issued)
//  rd_rel   out  1   1-cycle pulse when rd_lvl falls (read issued)
//  din_q    out  W   latched data word -> FIFO in
//  busy     out  1   1 while either channel is not IDLE
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): synchronisers, counters and din_q <= 0;
//    both FSMs -> IDLE; all outputs 0. Reset never generates wr_rel/rd_rel.
//  - Sync: each of wr_btn, rd_btn, sw[W-1:0] passes a 2-FF synchroniser; s = 2nd stage.
//  - Per-channel FSM, states IDLE, ARM, HELD, DISARM; cnt is CNT_W bits:
//    IDLE:   s=1 and grant=1 -> ARM, cnt<=1. Otherwise stay.
//    ARM:    s=0 -> IDLE. cnt==DB_CYCLES-1 -> HELD, lvl<=1. Else cnt<=cnt+1.
//    HELD:   s=0 -> DISARM, cnt<=1. lvl stays 1.
//    DISARM: s=1 -> HELD (bounce, no pulse).
//            cnt==DB_CYCLES-1 -> IDLE, lvl<=0, rel<=1 for that cycle only.
//            Else cnt<=cnt+1.
//  - Latency: clean raw edge -> lvl edge is exactly DB_CYCLES+2 posedges; this
//    holds in both directions. Any bounce restarts the count. A pulse shorter than
//    DB_CYCLES synced cycles produces no output.
//  - Lockout (grant):
//    wr channel: grant = (rd FSM == IDLE).
//    rd channel: grant = (wr FSM == IDLE) and not (wr FSM entering ARM this cycle).
//    Result: simultaneous presses -> wr wins. A held rd arms only after wr returns
//    to IDLE, and its count restarts from 1. wr_lvl and rd_lvl are never both 1.
//  - Data latch: din_q <= synced sw on the posedge where wr FSM goes ARM->HELD.
//    din_q holds through HELD/DISARM and afterwards until the next accepted write
//    press. Switch changes while wr is held are ignored.
//    This keeps FIFO `in` stable through its delayed falling-edge sample.
//  - busy = (wr FSM != IDLE) | (rd FSM != IDLE); purely combinational from state.
//  - Reset mid-press: outputs clear on the reset edge. If the button is still held,
//    the channel re-debounces from IDLE: lvl re-rises DB_CYCLES+2 posedges after
//    the first posedge with rst=0.
//  - Counter never wraps: it is bounded by DB_CYCLES-1 < 2**CNT_W.
// STRUCTURE
//  - Shared package fifo_in_pkg: 2-bit state typedef (IDLE=0, ARM=1, HELD=2,
//    DISARM=3); default DB_CYCLES/CNT_W constants.
//  - Sub-module db_channel: 2-FF sync, FSM, counter, lvl/rel outputs and a grant
//    input. Instantiated twice (wr, rd).
//  - Top level: sw synchroniser, grant/lockout logic, din_q latch, busy.
// TESTING (DB_CYCLES=4, W=3)
//  1 Clean press: sw=3'b101, wr_btn 1 for 20 cycles then 0
//    -> wr_lvl rises at posedge 6 after press; din_q=3'b101 from that same edge;
//       wr_lvl falls 6 posedges after release; wr_rel high exactly 1 cycle.
//  2 Bounce: wr_btn 1,1,0,1 (then held) -> no wr_lvl until 4 consecutive synced
//    highs; exactly one wr_lvl rise and one wr_rel in total.
//  3 Glitch: rd_btn high 3 cycles -> rd_lvl and rd_rel stay 0; busy pulses only
//    while ARM.
//  4 Simultaneous: wr_btn and rd_btn rise on the same cycle; release wr after 15
//    cycles, keep rd held
//    -> wr_lvl only; rd_lvl rises 4 posedges after wr FSM reaches IDLE (rd count
//       restarts at 1); wr_lvl and rd_lvl never overlap.
//  5 Switch change while held: wr in HELD, sw 3'b101->3'b010 -> din_q stays 3'b101
//    until the next accepted write press.
//  6 Reset mid-HELD: rst=1 for 1 cycle with wr_btn held
//    -> wr_lvl=0 and din_q=0 on that edge; no wr_rel; wr_lvl re-rises at the 6th
//       posedge after rst=0.

Source files
------------

// File: rtl/fifo_in_pkg.sv
// Shared types and defaults for the FIFO input debouncer.
// Per-channel FSM states plus default debounce timing constants.
package fifo_in_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    DISARM = 2'd3
  } db_state_e;

  localparam int DB_CYCLES_DEF = 1_000_000;
  localparam int CNT_W_DEF     = 20;

endpackage

// File: rtl/db_channel.sv
// One debounced button channel: 2-FF sync, press/release FSM,
// stable-cycle counter, level output and one-cycle release pulse.
module db_channel
  import fifo_in_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btn_i,
  input  logic      grant_i,
  output db_state_e state_o,
  output logic      start_o,
  output logic      accept_o,
  output logic      lvl_o,
  output logic      rel_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lvl_q;
  logic             rel_q;
  logic             s;

  assign s        = sync_q[1];
  assign state_o  = state_q;
  assign lvl_o    = lvl_q;
  assign rel_o    = rel_q;
  assign start_o  = (state_q == IDLE) && s && grant_i;
  assign accept_o = (state_q == ARM) && s && (cnt_q == LAST);

  // Synchroniser, debounce FSM and registered level/pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      rel_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_o) begin
            state_q <= ARM;
            cnt_q   <= CNT_W'(1);
          end
        end
        ARM: begin
          if (!s) begin
            state_q <= IDLE;
          end else if (cnt_q == LAST) begin
            state_q <= HELD;
            lvl_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state_q <= DISARM;
            cnt_q   <= CNT_W'(1);
          end
        end
        DISARM: begin
          if (s) begin
            state_q <= HELD;
          end else if (cnt_q == LAST) begin
            state_q <= IDLE;
            lvl_q   <= 1'b0;
            rel_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fifo_input_debouncer.sv
// Front end for the board FIFO: debounced wr/rd with wr-priority
// lockout, synchronised data switches latched on write acceptance.
module fifo_input_debouncer
  import fifo_in_pkg::*;
#(
  parameter int W         = 3,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_btn,
  input  logic         rd_btn,
  input  logic [W-1:0] sw,
  output logic         wr_lvl,
  output logic         rd_lvl,
  output logic         wr_rel,
  output logic         rd_rel,
  output logic [W-1:0] din_q,
  output logic         busy
);

  db_state_e    wr_state;
  db_state_e    rd_state;
  logic         wr_start;
  logic         wr_accept;
  logic         rd_start;
  logic         rd_accept;
  logic         wr_grant;
  logic         rd_grant;
  logic         rd_unused;
  logic [W-1:0] sw_meta_q;
  logic [W-1:0] sw_sync_q;

  // Write wins ties: read may only arm when write is idle and not arming.
  assign wr_grant  = (rd_state == IDLE);
  assign rd_grant  = (wr_state == IDLE) && !wr_start;
  assign busy      = (wr_state != IDLE) || (rd_state != IDLE);
  assign rd_unused = rd_start | rd_accept;

  db_channel #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_wr (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (wr_btn),
    .grant_i  (wr_grant),
    .state_o  (wr_state),
    .start_o  (wr_start),
    .accept_o (wr_accept),
    .lvl_o    (wr_lvl),
    .rel_o    (wr_rel)
  );

  db_channel #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_rd (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (rd_btn),
    .grant_i  (rd_grant),
    .state_o  (rd_state),
    .start_o  (rd_start),
    .accept_o (rd_accept),
    .lvl_o    (rd_lvl),
    .rel_o    (rd_rel)
  );

  // Switch synchroniser; word captured only when a write press is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      din_q     <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      if (wr_accept) begin
        din_q <= sw_sync_q;
      end
    end
  end

endmodule

// File: tb/tb_fifo_input_debouncer.sv
// Directed bench for fifo_input_debouncer with DB_CYCLES=4.
// Expected level events are queued at stimulus time and matched on output.
module tb_fifo_input_debouncer;

  localparam int W  = 3;
  localparam int DB = 4;
  localparam int LAT = DB + 2;

  localparam int WR_RISE = 0;
  localparam int WR_FALL = 1;
  localparam int WR_DROP = 2;
  localparam int RD_RISE = 3;
  localparam int RD_FALL = 4;
  localparam int RD_DROP = 5;

  typedef struct packed {
    int       kind;
    int       cyc;
    logic [2:0] din;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_btn;
  logic         rd_btn;
  logic [W-1:0] sw;
  logic         wr_lvl;
  logic         rd_lvl;
  logic         wr_rel;
  logic         rd_rel;
  logic [W-1:0] din_q;
  logic         busy;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  c;
  bit  mon_en = 1'b0;
  logic p_wr = 1'b0;
  logic p_rd = 1'b0;
  ev_t evq[$];

  fifo_input_debouncer #(
    .W         (W),
    .DB_CYCLES (DB),
    .CNT_W     (20)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_btn (wr_btn),
    .rd_btn (rd_btn),
    .sw     (sw),
    .wr_lvl (wr_lvl),
    .rd_lvl (rd_lvl),
    .wr_rel (wr_rel),
    .rd_rel (rd_rel),
    .din_q  (din_q),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int at, input logic [2:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.din  = d;
    evq.push_back(e);
  endtask

  task automatic match(input int kind);
    ev_t e;
    chk("evq_nonempty", 32'(evq.size() != 0), 32'd1);
    if (evq.size() != 0) begin
      e = evq.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      chk("ev_cycle", 32'(cyc), 32'(e.cyc));
      chk("ev_din", 32'(din_q), 32'(e.din));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: level edges against the scoreboard, pulse and overlap rules.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_lvl !== p_wr) begin
        match(wr_lvl ? WR_RISE : (wr_rel ? WR_FALL : WR_DROP));
      end
      if (rd_lvl !== p_rd) begin
        match(rd_lvl ? RD_RISE : (rd_rel ? RD_FALL : RD_DROP));
      end
      if (wr_rel) chk("wr_rel_on_fall", 32'(p_wr && !wr_lvl), 32'd1);
      if (rd_rel) chk("rd_rel_on_fall", 32'(p_rd && !rd_lvl), 32'd1);
      chk("no_overlap", 32'(wr_lvl & rd_lvl), 32'd0);
    end
    p_wr = wr_lvl;
    p_rd = rd_lvl;
  end

  initial begin
    rst    = 1'b1;
    wr_btn = 1'b0;
    rd_btn = 1'b0;
    sw     = '0;
    step(3);
    chk("rst_wr_lvl", 32'(wr_lvl), 32'd0);
    chk("rst_rd_lvl", 32'(rd_lvl), 32'd0);
    chk("rst_wr_rel", 32'(wr_rel), 32'd0);
    chk("rst_rd_rel", 32'(rd_rel), 32'd0);
    chk("rst_din", 32'(din_q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    mon_en = 1'b1;
    rst = 1'b0;
    step(3);

    // 1 clean press
    sw = 3'b101;
    step(3);
    wr_btn = 1'b1;
    c = cyc;
    push(WR_RISE, c + LAT, 3'b101);
    step(20);
    chk("t1_busy_held", 32'(busy), 32'd1);
    wr_btn = 1'b0;
    c = cyc;
    push(WR_FALL, c + LAT, 3'b101);
    step(10);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // 2 bounce
    sw = 3'b011;
    step(3);
    c = cyc;
    wr_btn = 1'b1;
    step(1);
    wr_btn = 1'b1;
    step(1);
    wr_btn = 1'b0;
    step(1);
    wr_btn = 1'b1;
    push(WR_RISE, c + 3 + LAT, 3'b011);
    step(15);
    wr_btn = 1'b0;
    c = cyc;
    push(WR_FALL, c + LAT, 3'b011);
    step(10);

    // 3 glitch on read
    rd_btn = 1'b1;
    c = cyc;
    step(3);
    rd_btn = 1'b0;
    chk("t3_busy_arm", 32'(busy), 32'd1);
    step(3);
    chk("t3_busy_back", 32'(busy), 32'd0);
    chk("t3_rd_lvl", 32'(rd_lvl), 32'd0);
    step(5);

    // 4 simultaneous press, write wins
    sw = 3'b110;
    step(3);
    wr_btn = 1'b1;
    rd_btn = 1'b1;
    c = cyc;
    push(WR_RISE, c + LAT, 3'b110);
    step(15);
    wr_btn = 1'b0;
    c = cyc;
    push(WR_FALL, c + LAT, 3'b110);
    push(RD_RISE, c + LAT + DB, 3'b110);
    step(20);
    chk("t4_rd_held", 32'(rd_lvl), 32'd1);
    rd_btn = 1'b0;
    c = cyc;
    push(RD_FALL, c + LAT, 3'b110);
    step(10);

    // 5 switch change while held
    sw = 3'b101;
    step(3);
    wr_btn = 1'b1;
    c = cyc;
    push(WR_RISE, c + LAT, 3'b101);
    step(10);
    sw = 3'b010;
    step(5);
    chk("t5_din_held", 32'(din_q), 32'd5);
    wr_btn = 1'b0;
    c = cyc;
    push(WR_FALL, c + LAT, 3'b101);
    step(10);
    chk("t5_din_after", 32'(din_q), 32'd5);
    wr_btn = 1'b1;
    c = cyc;
    push(WR_RISE, c + LAT, 3'b010);
    step(10);

    // 6 reset while held
    rst = 1'b1;
    c = cyc;
    push(WR_DROP, c + 1, 3'b000);
    step(1);
    chk("t6_lvl_rst", 32'(wr_lvl), 32'd0);
    chk("t6_din_rst", 32'(din_q), 32'd0);
    chk("t6_rel_rst", 32'(wr_rel), 32'd0);
    rst = 1'b0;
    c = cyc;
    push(WR_RISE, c + LAT, 3'b010);
    step(12);
    wr_btn = 1'b0;
    c = cyc;
    push(WR_FALL, c + LAT, 3'b010);
    step(12);

    chk("evq_drained", 32'(evq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
